// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Shared definitions for the boot-time instruction memory loader:
//   loader FSM state encoding and byte/word geometry constants.
package imem_loader_pkg;

   localparam int BYTE_W         = 8;
   localparam int WORD_W         = 32;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      HDR_LO = 3'd1,
      HDR_HI = 3'd2,
      DATA   = 3'd3,
      CHK    = 3'd4,
      DONE   = 3'd5
   } state_t;

endpackage

// File: rtl/imem_word_packer.sv
// imem_word_packer
//   Packs a little-endian byte stream into 32-bit words.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     clear        synchronous clear of byte index and partial word
//     byte_valid   byte_data is consumed this cycle
//     byte_data    incoming byte
//     word         assembled word (valid together with word_done)
//     word_done    high in the cycle the 4th byte of a word is consumed
module imem_word_packer
   import imem_loader_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_data,
   output logic [WORD_W-1:0] word,
   output logic              word_done
);

   logic [1:0]               byte_idx_reg;
   // Only the first three bytes need storage; the 4th is taken straight from
   // the input so the word is available in the same cycle it completes.
   logic [WORD_W-BYTE_W-1:0] shift_reg;

   assign word      = {byte_data, shift_reg};
   assign word_done = byte_valid && (byte_idx_reg == 2'(BYTES_PER_WORD - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte_idx_reg <= '0;
         shift_reg    <= '0;
      end else if (clear) begin
         byte_idx_reg <= '0;
         shift_reg    <= '0;
      end else if (byte_valid) begin
         byte_idx_reg <= byte_idx_reg + 2'd1;
         // Newest byte enters at the top, so byte 0 ends up in bits 7:0.
         shift_reg    <= {byte_data, shift_reg[WORD_W-BYTE_W-1:BYTE_W]};
      end
   end

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time loader: parses a 16-bit word count header, packs data bytes
//   into words written to instruction memory, verifies an XOR checksum and
//   releases the CPU from reset only after a clean load.
//   Ports:
//     clk, reset          clock, asynchronous active-high reset
//     start               pulse; begins a load from IDLE or DONE
//     rx_data/valid/ready byte stream input handshake
//     im_we/addr/wdata    instruction memory write port
//     cpu_reset           CPU reset hold, low only after a good load
//     busy, done, err     load status
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int ADDR_W = 14,
   parameter int DEPTH  = 1 << ADDR_W
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              im_we,
   output logic [ADDR_W-1:0] im_addr,
   output logic [31:0]       im_wdata,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [16:0] DEPTH_L = 17'(DEPTH);

   state_t      state;
   logic [14:0] word_idx;
   logic [15:0] n_reg;
   logic [7:0]  xor_reg;

   logic        accept;
   logic [15:0] header_n;
   logic        last_word;
   logic        pk_valid;
   logic        pk_clear;
   logic [31:0] pk_word;
   logic        pk_done;

   always_comb begin
      rx_ready = 1'b0;
      case (state)
         HDR_LO, HDR_HI, DATA, CHK: rx_ready = 1'b1;
         default:                   rx_ready = 1'b0;
      endcase
   end

   assign accept    = rx_valid && rx_ready;
   assign header_n  = {rx_data, n_reg[7:0]};
   assign last_word = (({1'b0, word_idx}) + 16'd1) == n_reg;
   assign pk_valid  = accept && (state == DATA);
   // Holding the packer cleared outside DATA guarantees each load starts
   // on a word boundary.
   assign pk_clear  = (state != DATA);

   imem_word_packer u_packer (
      .clk        (clk),
      .reset      (reset),
      .clear      (pk_clear),
      .byte_valid (pk_valid),
      .byte_data  (rx_data),
      .word       (pk_word),
      .word_done  (pk_done)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         word_idx  <= '0;
         n_reg     <= '0;
         xor_reg   <= '0;
         im_we     <= 1'b0;
         im_addr   <= '0;
         im_wdata  <= '0;
         cpu_reset <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         im_we <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= HDR_LO;
                  busy  <= 1'b1;
               end
            end
            HDR_LO: begin
               if (accept) begin
                  n_reg[7:0] <= rx_data;
                  state      <= HDR_HI;
               end
            end
            HDR_HI: begin
               if (accept) begin
                  n_reg[15:8] <= rx_data;
                  word_idx    <= '0;
                  xor_reg     <= '0;
                  if ({1'b0, header_n} > DEPTH_L) begin
                     // Oversized image: reject without consuming anything more.
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else if (header_n == 16'd0) begin
                     state <= CHK;
                  end else begin
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (accept) begin
                  xor_reg <= xor_reg ^ rx_data;
                  if (pk_done) begin
                     im_we    <= 1'b1;
                     im_addr  <= word_idx[ADDR_W-1:0];
                     im_wdata <= pk_word;
                     word_idx <= word_idx + 15'd1;
                     if (last_word) begin
                        state <= CHK;
                     end
                  end
               end
            end
            CHK: begin
               if (accept) begin
                  state     <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  err       <= (rx_data != xor_reg);
                  cpu_reset <= (rx_data != xor_reg);
               end
            end
            DONE: begin
               if (start) begin
                  state     <= HDR_LO;
                  busy      <= 1'b1;
                  done      <= 1'b0;
                  err       <= 1'b0;
                  cpu_reset <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader: directed loads from the test plan
//   plus randomized loads, compared against a stream-level reference model.
module tb_imem_loader;

   localparam int ADDR_W = 14;
   localparam int DEPTH  = 1 << ADDR_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              rx_ready;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              cpu_reset;
   logic              busy;
   logic              done;
   logic              err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   wr_t obs_wr[$];

   imem_loader #(.ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .im_we     (im_we),
      .im_addr   (im_addr),
      .im_wdata  (im_wdata),
      .cpu_reset (cpu_reset),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   // Every write strobe seen by memory, sampled mid-cycle.
   always @(negedge clk) begin
      if (!reset && im_we) obs_wr.push_back('{addr: im_addr, data: im_wdata});
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_rx_ready"}, rx_ready, 0);
      chk({tag, "_im_we"}, im_we, 0);
      chk({tag, "_im_addr"}, im_addr, 0);
      chk({tag, "_im_wdata"}, im_wdata, 0);
      chk({tag, "_cpu_reset"}, cpu_reset, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_err"}, err, 0);
   endtask

   // One load: builds the byte stream from header count, words and a
   // checksum corruption mask, then drives and checks it.
   //   gap_pct    chance (percent) of an idle cycle before each byte
   //   start_at   byte index at which a stray start pulse is driven (-1 none)
   //   stop_after number of bytes to send before abandoning (-1 all)
   task automatic run_load(input string tag, input logic [15:0] n,
                           input logic [31:0] words[$], input logic [7:0] flip,
                           input int gap_pct, input int start_at, input int stop_after);
      logic [7:0] bytes[$];
      logic [7:0] sum;
      logic       overflow;
      logic       err_exp;
      int         nsend;
      int         guard;
      int         exp_writes;
      int         di;

      // Reference model: stream layout and expected outcome.
      overflow = (int'(n) > DEPTH);
      sum = 8'h00;
      bytes.push_back(n[7:0]);
      bytes.push_back(n[15:8]);
      if (!overflow) begin
         foreach (words[w]) begin
            for (int b = 0; b < 4; b++) begin
               bytes.push_back(8'((words[w] >> (8 * b)) & 32'hFF));
               sum ^= 8'((words[w] >> (8 * b)) & 32'hFF);
            end
         end
         bytes.push_back(sum ^ flip);
      end
      err_exp = overflow || (flip != 8'h00);
      nsend   = (stop_after < 0) ? bytes.size() : stop_after;

      obs_wr.delete();

      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, "_start_busy"}, busy, 1);
      chk({tag, "_start_done"}, done, 0);
      chk({tag, "_start_err"}, err, 0);
      chk({tag, "_start_cpu_reset"}, cpu_reset, 1);

      for (int k = 0; k < nsend; k++) begin
         while ($urandom_range(99) < gap_pct) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            @(negedge clk);
         end
         rx_valid = 1'b1;
         rx_data  = bytes[k];
         start    = (k == start_at);
         guard    = 0;
         while (!rx_ready && guard < 20) begin
            @(negedge clk);
            guard++;
         end
         if (!rx_ready) begin
            chk({tag, "_ready_timeout"}, 0, 1);
            rx_valid = 1'b0;
            start    = 1'b0;
            return;
         end
         @(posedge clk);
         @(negedge clk);
         rx_valid = 1'b0;
         start    = 1'b0;

         di = k - 2;
         if (di >= 0 && di < 4 * words.size() && !overflow) begin
            chk($sformatf("%s_we_b%0d", tag, k), im_we, ((di % 4) == 3) ? 1 : 0);
            if ((di % 4) == 3) begin
               chk($sformatf("%s_addr_w%0d", tag, di / 4), im_addr, di / 4);
               chk($sformatf("%s_data_w%0d", tag, di / 4), im_wdata, words[di / 4]);
            end
         end
         if (k == bytes.size() - 1) begin
            chk({tag, "_done"}, done, 1);
            chk({tag, "_busy"}, busy, 0);
            chk({tag, "_err"}, err, err_exp);
            chk({tag, "_cpu_reset"}, cpu_reset, err_exp);
            if (overflow) chk({tag, "_rx_ready_after_hdr"}, rx_ready, 0);
         end
      end

      repeat (3) @(negedge clk);
      if (overflow) exp_writes = 0;
      else if (nsend >= bytes.size()) exp_writes = words.size();
      else exp_writes = (nsend > 2) ? (nsend - 2) / 4 : 0;
      chk({tag, "_write_count"}, obs_wr.size(), exp_writes);
      for (int i = 0; i < exp_writes && i < obs_wr.size(); i++) begin
         chk($sformatf("%s_wr%0d_addr", tag, i), obs_wr[i].addr, i);
         chk($sformatf("%s_wr%0d_data", tag, i), obs_wr[i].data, words[i]);
      end
      $display("load %s n=%0d writes=%0d done=%0b err=%0b cpu_reset=%0b",
               tag, n, obs_wr.size(), done, err, cpu_reset);
   endtask

   initial begin
      logic [31:0] w2[$];
      logic [31:0] w0[$];
      logic [31:0] wa5[$];
      logic [31:0] wr[$];
      int          nr;

      w2  = '{32'h12345678, 32'hDEADBEEF};
      wa5 = '{32'hA5A5A5A5};

      reset    = 1'b1;
      start    = 1'b0;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      repeat (2) @(negedge clk);
      chk_reset_values("por");
      reset = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      run_load("good2", 16'd2, w2, 8'h00, 0, -1, -1);
      run_load("badchk", 16'd2, w2, 8'h01, 0, -1, -1);
      run_load("oversize", 16'h4001, w0, 8'h00, 0, -1, -1);
      run_load("empty", 16'd0, w0, 8'h00, 0, -1, -1);
      run_load("gaps", 16'd2, w2, 8'h00, 40, 4, -1);

      // Abandon after byte 2 of word 1, then reset mid-load.
      run_load("abort", 16'd2, w2, 8'h00, 0, -1, 8);
      reset = 1'b1;
      #1;
      chk_reset_values("midreset");
      @(negedge clk);
      reset = 1'b0;
      run_load("reload", 16'd1, wa5, 8'h00, 0, -1, -1);

      for (int t = 0; t < 3; t++) begin
         wr.delete();
         nr = $urandom_range(6, 1);
         for (int i = 0; i < nr; i++) wr.push_back($urandom);
         run_load($sformatf("rand%0d", t), 16'(nr), wr,
                  (t == 1) ? 8'($urandom_range(255, 1)) : 8'h00, 30, 3 + t, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
